// File: rtl/digi_pattern_source_if.sv
// Control and observation bundle for digi_pattern_source: pattern load port,
// playback controls and the registered channel outputs.
interface digi_pattern_source_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned DIV_W    = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic                load_en;
    logic [AW-1:0]       load_addr;
    logic [CHANNELS-1:0] load_data;
    logic [AW:0]         len;
    logic [DIV_W-1:0]    div;
    logic                repeat_mode;
    logic                start;
    logic                stop;
    logic [CHANNELS-1:0] out;
    logic                busy;
    logic                step;
    logic                done;

    modport master (
        output load_en, load_addr, load_data, len, div, repeat_mode, start, stop,
        input  out, busy, step, done
    );

    modport slave (
        input  load_en, load_addr, load_data, len, div, repeat_mode, start, stop,
        output out, busy, step, done
    );
endinterface

// File: rtl/digi_pattern_source.sv
// Multi-channel digital stimulus source: replays a loaded pattern, one word
// per step with programmable dwell, in one-shot or repeat mode.
module digi_pattern_source #(
    parameter int unsigned         CHANNELS = 4,
    parameter int unsigned         DEPTH    = 16,
    parameter int unsigned         DIV_W    = 16,
    parameter logic [CHANNELS-1:0] IDLE_VAL = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digi_pattern_source_if.slave  bus
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned LEN_W = AW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state_q, state_d;
    logic [CHANNELS-1:0] out_q, out_d;
    logic                step_q, step_d;
    logic                done_q, done_d;
    logic [AW-1:0]       idx_q, idx_d;
    logic [DIV_W-1:0]    presc_q, presc_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                rep_q, rep_d;

    logic [CHANNELS-1:0] mem [DEPTH];

    logic len_ok;
    logic not_last;

    assign len_ok   = (bus.len != '0) && (bus.len <= LEN_W'(DEPTH));
    assign not_last = ({1'b0, idx_q} < (len_q - 1'b1));

    // Pattern memory is not reset; writes are only accepted while idle.
    always_ff @(posedge clk) begin
        if (bus.load_en && (state_q == IDLE)) begin
            mem[bus.load_addr] <= bus.load_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= IDLE_VAL;
            step_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
            presc_q <= '0;
            len_q   <= '0;
            div_q   <= '0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            step_q  <= step_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
            presc_q <= presc_d;
            len_q   <= len_d;
            div_q   <= div_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        step_d  = 1'b0;
        done_d  = 1'b0;
        idx_d   = idx_q;
        presc_d = presc_q;
        len_d   = len_q;
        div_d   = div_q;
        rep_d   = rep_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.stop && len_ok) begin
                    state_d = RUN;
                    len_d   = bus.len;
                    div_d   = bus.div;
                    rep_d   = bus.repeat_mode;
                    idx_d   = '0;
                    out_d   = mem[0];
                    step_d  = 1'b1;
                    presc_d = bus.div;
                end
            end
            RUN: begin
                // Stop outranks step progression and suppresses done.
                if (bus.stop) begin
                    state_d = IDLE;
                    out_d   = IDLE_VAL;
                    idx_d   = '0;
                    presc_d = '0;
                end else if (presc_q != '0) begin
                    presc_d = presc_q - 1'b1;
                end else if (not_last) begin
                    idx_d   = idx_q + 1'b1;
                    out_d   = mem[idx_q + 1'b1];
                    step_d  = 1'b1;
                    presc_d = div_q;
                end else if (rep_q) begin
                    idx_d   = '0;
                    out_d   = mem[0];
                    step_d  = 1'b1;
                    presc_d = div_q;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out  = out_q;
    assign bus.busy = (state_q == RUN);
    assign bus.step = step_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_digi_pattern_source.sv
// Directed bench for digi_pattern_source with CHANNELS=4, DEPTH=16, IDLE_VAL=4'hA.
module tb_digi_pattern_source;
    logic clk = 1'b0;
    logic rst_n = 1'b1;

    digi_pattern_source_if #(.CHANNELS(4), .DEPTH(16), .DIV_W(16)) bus ();

    digi_pattern_source #(
        .CHANNELS(4),
        .DEPTH   (16),
        .DIV_W   (16),
        .IDLE_VAL(4'hA)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [3:0] model [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [3:0] addr, input logic [3:0] data);
        bus.load_en   = 1'b1;
        bus.load_addr = addr;
        bus.load_data = data;
        tick();
        bus.load_en = 1'b0;
        model[addr] = data;
    endtask

    task automatic start_run(input logic [4:0] l, input logic [15:0] d, input logic r);
        bus.len         = l;
        bus.div         = d;
        bus.repeat_mode = r;
        bus.start       = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    // Expected waveform from the first step pulse (cycle 1) onward; poke drives
    // a write, a div/len change and a start while the run is busy.
    task automatic follow(input string tag, input int len, input int d, input bit rep,
                          input int ncyc, input bit poke);
        int k;
        logic [3:0] e_out;
        bit e_step, e_busy, e_done;
        for (int c = 1; c <= ncyc; c++) begin
            k = (c - 1) / (d + 1);
            if (rep || k < len) begin
                e_out  = model[k % len];
                e_step = ((c - 1) % (d + 1)) == 0;
                e_busy = 1'b1;
                e_done = 1'b0;
            end else begin
                e_out  = model[len - 1];
                e_step = 1'b0;
                e_busy = 1'b0;
                e_done = (c == len * (d + 1) + 1);
            end
            check($sformatf("%s c%0d out", tag, c), 32'(bus.out), 32'(e_out));
            check($sformatf("%s c%0d step", tag, c), 32'(bus.step), 32'(e_step));
            check($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'(e_busy));
            check($sformatf("%s c%0d done", tag, c), 32'(bus.done), 32'(e_done));
            if (poke && c == 2) begin
                bus.load_en   = 1'b1;
                bus.load_addr = 4'h0;
                bus.load_data = 4'hF;
                bus.div       = 16'd7;
                bus.len       = 5'd1;
                bus.start     = 1'b1;
            end else if (poke && c == 3) begin
                bus.load_en = 1'b0;
                bus.start   = 1'b0;
            end
            tick();
        end
    endtask

    initial begin
        bus.load_en = 1'b0; bus.load_addr = '0; bus.load_data = '0;
        bus.len = '0; bus.div = '0; bus.repeat_mode = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        check("reset out", 32'(bus.out), 32'hA);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset step", 32'(bus.step), 32'd0);
        check("reset done", 32'(bus.done), 32'd0);
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();

        // One-shot len=3 div=2, with write/div/start pokes mid-run
        write_word(4'd0, 4'h1);
        write_word(4'd1, 4'h2);
        write_word(4'd2, 4'h4);
        start_run(5'd3, 16'd2, 1'b0);
        follow("oneshot", 3, 2, 1'b0, 12, 1'b1);

        // mem[0] untouched by the busy write
        start_run(5'd3, 16'd2, 1'b0);
        follow("reuse", 3, 2, 1'b0, 11, 1'b0);

        write_word(4'd0, 4'hF);
        start_run(5'd3, 16'd0, 1'b0);
        follow("newword", 3, 0, 1'b0, 5, 1'b0);

        // Repeat, div=0, then stop
        write_word(4'd0, 4'h5);
        write_word(4'd1, 4'hA);
        start_run(5'd2, 16'd0, 1'b1);
        follow("rep", 2, 0, 1'b1, 6, 1'b0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop out", 32'(bus.out), 32'hA);
        check("stop busy", 32'(bus.busy), 32'd0);
        check("stop done", 32'(bus.done), 32'd0);
        tick();
        check("stop done later", 32'(bus.done), 32'd0);
        check("stop step later", 32'(bus.step), 32'd0);

        // Illegal starts
        start_run(5'd0, 16'd0, 1'b0);
        check("len0 busy", 32'(bus.busy), 32'd0);
        check("len0 step", 32'(bus.step), 32'd0);
        start_run(5'd17, 16'd0, 1'b0);
        check("len17 busy", 32'(bus.busy), 32'd0);
        bus.stop = 1'b1;
        start_run(5'd2, 16'd0, 1'b0);
        bus.stop = 1'b0;
        check("startstop busy", 32'(bus.busy), 32'd0);
        check("startstop out", 32'(bus.out), 32'hA);
        tick();
        check("startstop busy later", 32'(bus.busy), 32'd0);

        // Full-depth contents, distinct words
        for (int i = 0; i < 16; i++) write_word(4'(i), 4'((i * 7 + 3) % 16));

        // start held through done re-runs one cycle later
        bus.len = 5'd1; bus.div = 16'd0; bus.repeat_mode = 1'b0;
        bus.start = 1'b1;
        tick();
        check("hold c1 busy", 32'(bus.busy), 32'd1);
        check("hold c1 step", 32'(bus.step), 32'd1);
        check("hold c1 out", 32'(bus.out), 32'h3);
        tick();
        check("hold c2 done", 32'(bus.done), 32'd1);
        check("hold c2 busy", 32'(bus.busy), 32'd0);
        tick();
        check("hold c3 busy", 32'(bus.busy), 32'd1);
        check("hold c3 step", 32'(bus.step), 32'd1);
        check("hold c3 done", 32'(bus.done), 32'd0);
        bus.start = 1'b0;
        tick();
        check("hold c4 done", 32'(bus.done), 32'd1);
        tick();
        check("hold c5 busy", 32'(bus.busy), 32'd0);
        check("hold c5 done", 32'(bus.done), 32'd0);

        // Full depth wrap, three 32-cycle periods
        start_run(5'd16, 16'd1, 1'b1);
        follow("wrap", 16, 1, 1'b1, 96, 1'b0);

        // Asynchronous reset mid-run
        check("prereset busy", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset out", 32'(bus.out), 32'hA);
        check("midreset busy", 32'(bus.busy), 32'd0);
        check("midreset step", 32'(bus.step), 32'd0);
        check("midreset done", 32'(bus.done), 32'd0);
        #1 rst_n = 1'b1;
        tick();
        check("postreset busy", 32'(bus.busy), 32'd0);
        check("postreset done", 32'(bus.done), 32'd0);
        check("postreset out", 32'(bus.out), 32'hA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/digi_pattern_source.md
Name: digi_pattern_source

Overview:
- Parametrised, clocked multi-channel digital stimulus source.
- Successor to the fixed analog source primitives: it replays a user-loaded bit pattern, one word per step, onto CHANNELS parallel outputs.
- Step dwell is programmable; one-shot and repeat modes are supported.
- Sits at the test-harness boundary and drives digital nets in mixed-mode netlists.

Parameters:
- CHANNELS, 4, number of output channels (width of each pattern word), 1..32.
- DEPTH, 16, pattern memory words, power of two, 2..256.
- DIV_W, 16, width of the step-dwell divider.
- IDLE_VAL, 0, value driven on out while idle (CHANNELS bits).
- AW, $clog2(DEPTH), derived address width; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_en  in  1  write pattern word; honoured only when busy=0.
- load_addr  in  AW  pattern write address.
- load_data  in  CHANNELS  pattern word.
- len  in  AW+1  pattern length in words, 1..DEPTH; sampled at start.
- div  in  DIV_W  dwell per step = div+1 clocks; sampled at start.
- repeat_mode  in  1  1 = wrap to word 0 after the last word, 0 = one-shot; sampled at start.
- start  in  1  level-sampled request to begin playback.
- stop  in  1  abort playback.
- out  out  CHANNELS  current pattern word, registered.
- busy  out  1  high in RUN.
- step  out  1  1-cycle pulse when out takes a new word, including word 0.
- done  out  1  1-cycle pulse when a one-shot pattern completes.

Behaviour:
- Reset (async assert, sync release): state=IDLE, out=IDLE_VAL, busy=0, step=0, done=0, index=0, prescaler=0. Pattern memory contents are not reset.
- Memory: a write occurs on a clk edge with load_en=1 and busy=0. A load_en while busy=1 is dropped with no side effects. Read is combinational from an index register, so out is registered with one cycle of latency.
- States: IDLE, RUN.
- IDLE -> RUN: on start=1, stop=0, len!=0 and len<=DEPTH.
  - On that edge, latch len/div/repeat_mode.
  - Next cycle: out=mem[0], step=1, busy=1, prescaler=div.
  - A start with len=0 or len>DEPTH is ignored and stays IDLE.
- RUN, each clk:
  - If prescaler!=0, decrement it.
  - Else, if index<len-1: index++, out=mem[index+1], step=1, prescaler reloads to div.
  - Else (last word has finished its dwell):
    - Repeat mode: index=0, out=mem[0], step=1, reload prescaler.
    - One-shot: -> IDLE, busy=0, done=1 for one cycle, out holds the last word until the next start or reset.
- Each word is held for exactly div+1 cycles. A one-shot run lasts len*(div+1) cycles from the first step pulse to the done pulse.
- stop=1 in RUN: next cycle -> IDLE, out=IDLE_VAL, busy=0, index=0, no done pulse. stop in IDLE has no effect.
- start and stop in the same cycle: stop wins, so no run starts.
- start while busy=1 is ignored. There is no retrigger.
- done and start in the same cycle: start is evaluated in IDLE on the following edge. Holding start high therefore re-runs one cycle after done.
- div=0: a new word every clock, with step high continuously in RUN.
- Changes to div, len or repeat_mode during RUN have no effect until the next start.
- Reset asserted mid-run: immediate return to reset values; no done pulse.

Test Plan:
- Reset state: CHANNELS=4, IDLE_VAL=4'hA; assert rst_n=0 mid-run -> out=4'hA, busy=0, step=0, done=0 immediately, before any clk edge.
- One-shot timing:
  - Stimulus: load mem[0..2]=4'h1,4'h2,4'h4; len=3, div=2, repeat_mode=0; start pulse.
  - Required: out = 1, 2, 4, each for exactly 3 cycles; step pulses at cycles 1, 4, 7 after start; done at cycle 10; out stays 4'h4 afterwards.
- Repeat with div=0:
  - Stimulus: len=2 with mem 4'h5, 4'hA; run 6 cycles, then stop.
  - Required: out sequence 5,A,5,A,5,A; step high every cycle; after stop, out=IDLE_VAL one cycle later; no done pulse.
- Write protection and sampling:
  - Stimulus: during RUN, load_en to address 0 with 4'hF, and change div from 2 to 7.
  - Required: the current run is unaffected; a subsequent IDLE run still shows the old mem[0] and dwell div+1=3 only if it is restarted with div=2. Write 4'hF again while idle -> the next run shows 4'hF.
- Illegal and simultaneous requests:
  - start with len=0 -> busy stays 0.
  - start+stop in the same cycle -> busy stays 0.
  - start while busy -> no restart; step timing unchanged.
- Full depth and wrap: DEPTH=16, len=16, repeat_mode=1, div=1 -> index wraps 15->0 with no skipped or repeated word; period 32 cycles, checked over 3 periods.
